dma_peripheral_port: RTL and testbench

Peripheral-side endpoint of the 8237A DMA handshake. The block raises DREQ on behalf of a local I/O device and answers the controller's DACK with IOR_N/IOW_N strobes. It buffers bytes in an internal FIFO, sourcing data onto the DMA data bus for device-to-memory transfers and capturing data for memory-to-device transfers. It honours EOP_N termination and sits between the DMA bus signals and the device's local valid/ready streams.

---
 rtl/dma_peripheral_port.sv | 192 +++++++++++++++++++
 tb/tb_dma_peripheral_port.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_peripheral_port.sv
// dma_peripheral_port: 8237A-style DMA peripheral endpoint.
// Raises DREQ for a local device, answers DACK with IOR_N/IOW_N strobes and
// buffers bytes in a small FIFO between the DMA bus and local valid/ready streams.
module dma_peripheral_port #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          arm,
  input  logic          dir,
  output logic          DREQ,
  input  logic          DACK,
  input  logic          IOR_N,
  input  logic          IOW_N,
  input  logic          EOP_N,
  input  logic [DW-1:0] DB_in,
  output logic [DW-1:0] DB_out,
  output logic          DB_oe,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready,
  output logic          done,
  output logic [15:0]   xfer_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, ACK, RECOVER} state_t;

  state_t          state_q, state_d;
  logic            dreq_q, dreq_d;
  logic            stb_q, stb_d;
  logic [DW-1:0]   hold_q, hold_d;
  logic            arm_q;
  logic            done_q, done_d;
  logic [15:0]     xfer_q, xfer_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            s_ready_q, s_ready_d;
  logic            m_valid_q, m_valid_d;
  logic [DW-1:0]   m_data_q, m_data_d;
  logic [DW-1:0]   mem_q [DEPTH];

  logic            stb_low, release_c, full, empty, req_cond, arm_rise;
  logic            push, pop;
  logic [DW-1:0]   push_data, head_d;

  // Bus strobe decode and FIFO occupancy flags
  always_comb begin
    stb_low   = dir ? !IOW_N : !IOR_N;
    release_c = stb_q && !stb_low;
    full      = (cnt_q == CW'(DEPTH));
    empty     = (cnt_q == CW'(0));
    req_cond  = arm && !done_q && (dir ? !full : !empty);
    arm_rise  = arm && !arm_q;
  end

  // Route FIFO push/pop between the bus side and the local stream by direction
  always_comb begin
    push      = 1'b0;
    pop       = 1'b0;
    push_data = s_data;
    if (!dir) begin
      push = s_valid && s_ready_q && !full;
      pop  = release_c && !empty;
    end else begin
      push      = release_c && !full;
      push_data = hold_q;
      pop       = m_valid_q && m_ready && !empty;
    end
  end

  // FIFO pointer/count update and next head value for the registered sink port
  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    head_d    = (push && (rd_ptr_d == wr_ptr_q)) ? push_data : mem_q[rd_ptr_d];
    m_valid_d = dir && (cnt_d != CW'(0));
    m_data_d  = m_valid_d ? head_d : '0;
    s_ready_d = !dir && (cnt_d != CW'(DEPTH));
  end

  // Handshake FSM: next state, strobe tracking and write-data hold capture
  always_comb begin
    state_d = state_q;
    stb_d   = 1'b0;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (req_cond) state_d = REQ;
      end
      REQ: begin
        if (DACK)           state_d = ACK;
        else if (!req_cond) state_d = IDLE;
      end
      ACK: begin
        if (release_c) begin
          state_d = RECOVER;
        end else if (!DACK) begin
          state_d = RECOVER;
        end else begin
          stb_d = stb_low;
          if (dir && !IOW_N) hold_d = DB_in;
        end
      end
      RECOVER: begin
        if (!DACK) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    dreq_d = (state_d == REQ);
  end

  // Terminal-count flag and byte counter, both cleared on a fresh arm
  always_comb begin
    done_d = done_q;
    xfer_d = xfer_q;
    if (arm_rise) begin
      done_d = 1'b0;
      xfer_d = 16'd0;
    end else begin
      if (DACK && !EOP_N) done_d = 1'b1;
      if (release_c)      xfer_d = xfer_q + 16'd1;
    end
  end

  // State registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      dreq_q    <= 1'b0;
      stb_q     <= 1'b0;
      hold_q    <= '0;
      arm_q     <= 1'b0;
      done_q    <= 1'b0;
      xfer_q    <= 16'd0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      dreq_q    <= dreq_d;
      stb_q     <= stb_d;
      hold_q    <= hold_d;
      arm_q     <= arm;
      done_q    <= done_d;
      xfer_q    <= xfer_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  // Bus drive is combinational so it collapses immediately on reset or strobe release
  always_comb begin
    DB_oe  = DACK && !IOR_N && !dir && (state_q == ACK);
    DB_out = (DB_oe && !empty) ? mem_q[rd_ptr_q] : '0;
  end

  assign DREQ       = dreq_q;
  assign s_ready    = s_ready_q;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign done       = done_q;
  assign xfer_count = xfer_q;

endmodule

// File: tb/tb_dma_peripheral_port.sv
// tb_dma_peripheral_port: directed stimulus with a queue-based scoreboard.
module tb_dma_peripheral_port;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 8;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          arm, dir;
  logic          DREQ, DACK, IOR_N, IOW_N, EOP_N;
  logic [DW-1:0] DB_in, DB_out;
  logic          DB_oe;
  logic          s_valid, s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid, m_ready;
  logic [DW-1:0] m_data;
  logic          done;
  logic [15:0]   xfer_count;

  int n_pass  = 0;
  int n_total = 0;

  logic [DW-1:0] bus_q [$];
  logic [DW-1:0] m_q   [$];
  logic          prev_oe = 1'b0;

  dma_peripheral_port #(.DEPTH(DEPTH), .DW(DW)) dut (
    .CLK(CLK), .RESET(RESET), .arm(arm), .dir(dir),
    .DREQ(DREQ), .DACK(DACK), .IOR_N(IOR_N), .IOW_N(IOW_N), .EOP_N(EOP_N),
    .DB_in(DB_in), .DB_out(DB_out), .DB_oe(DB_oe),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .done(done), .xfer_count(xfer_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: compare each bus byte and each sink handshake against the queues
  always @(negedge CLK) begin
    if (DB_oe && !prev_oe) begin
      if (bus_q.size() == 0) begin
        n_total++;
        $display("FAIL bus_byte: got 0x%0h expected nothing", DB_out);
      end else begin
        chk("bus_byte", 32'(DB_out), 32'(bus_q.pop_front()));
      end
    end
    prev_oe <= DB_oe;
    if (m_valid && m_ready) begin
      if (m_q.size() == 0) begin
        n_total++;
        $display("FAIL m_data: got 0x%0h expected nothing", m_data);
      end else begin
        chk("m_data", 32'(m_data), 32'(m_q.pop_front()));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_dreq(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (DREQ) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic dreq_quiet(input string name);
    bit any;
    any = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      any |= DREQ;
    end
    chk(name, 32'(any), 32'd0);
    @(posedge CLK);
    #1;
  endtask

  task automatic push_local(input logic [DW-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    @(posedge CLK);
    #1;
    s_valid = 1'b0;
  endtask

  // One complete DMA byte: DACK, two-cycle strobe, release, DACK drop
  task automatic dma_byte(input bit wr, input logic [DW-1:0] d, input bit eop);
    wait_dreq("dreq_wait");
    @(posedge CLK); #1;
    DACK = 1'b1;
    if (eop) EOP_N = 1'b0;
    @(posedge CLK); #1;
    if (wr) begin
      IOW_N = 1'b0;
      DB_in = d;
    end else begin
      IOR_N = 1'b0;
    end
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    IOR_N = 1'b1;
    IOW_N = 1'b1;
    EOP_N = 1'b1;
    @(posedge CLK); #1;
    DACK = 1'b0;
    @(posedge CLK); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; arm = 1'b0; dir = 1'b0;
    DACK = 1'b1; IOR_N = 1'b0; IOW_N = 1'b1; EOP_N = 1'b1;
    DB_in = '0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;

    // Reset with bus strobes active
    repeat (2) @(negedge CLK);
    chk("rst_dreq", 32'(DREQ), 32'd0);
    chk("rst_oe", 32'(DB_oe), 32'd0);
    chk("rst_db_out", 32'(DB_out), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_xfer", 32'(xfer_count), 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0; DACK = 1'b0; IOR_N = 1'b1;
    cyc(2);
    chk("s_ready_empty", 32'(s_ready), 32'd1);

    // Device-to-memory: two bytes sourced onto the bus
    push_local(8'hA5); bus_q.push_back(8'hA5);
    push_local(8'h3C); bus_q.push_back(8'h3C);
    arm = 1'b1;
    @(posedge CLK); @(negedge CLK);
    chk("dreq_arm", 32'(DREQ), 32'd1);
    dma_byte(1'b0, 8'h00, 1'b0);
    chk("xfer_1", 32'(xfer_count), 32'd1);
    dma_byte(1'b0, 8'h00, 1'b0);
    chk("xfer_2", 32'(xfer_count), 32'd2);
    dreq_quiet("dreq_fifo_empty");

    // Memory-to-device: fill the FIFO from the bus with no sink pops
    arm = 1'b0;
    cyc(1);
    dir = 1'b1;
    cyc(2);
    chk("s_ready_dir1", 32'(s_ready), 32'd0);
    chk("m_valid_empty", 32'(m_valid), 32'd0);
    arm = 1'b1;
    cyc(1);
    chk("xfer_rearm", 32'(xfer_count), 32'd0);
    m_q.push_back(8'h5A);
    dma_byte(1'b1, 8'h5A, 1'b0);
    chk("m_valid_1", 32'(m_valid), 32'd1);
    chk("m_data_head", 32'(m_data), 32'h5A);
    for (int i = 1; i < DEPTH; i++) begin
      logic [DW-1:0] d;
      d = DW'(8'h10 + i);
      m_q.push_back(d);
      dma_byte(1'b1, d, 1'b0);
    end
    chk("xfer_full", 32'(xfer_count), 32'(DEPTH));
    dreq_quiet("dreq_fifo_full");
    m_ready = 1'b1;
    cyc(1);
    m_ready = 1'b0;
    wait_dreq("dreq_after_pop");
    @(posedge CLK); #1;
    m_ready = 1'b1;
    cyc(DEPTH - 1);
    m_ready = 1'b0;
    arm = 1'b0;
    cyc(2);
    chk("m_valid_drained", 32'(m_valid), 32'd0);

    // EOP on the third byte stops requests with data remaining
    dir = 1'b0;
    cyc(2);
    push_local(8'h11); bus_q.push_back(8'h11);
    push_local(8'h22); bus_q.push_back(8'h22);
    push_local(8'h33); bus_q.push_back(8'h33);
    push_local(8'h44);
    arm = 1'b1;
    cyc(1);
    dma_byte(1'b0, 8'h00, 1'b0);
    dma_byte(1'b0, 8'h00, 1'b0);
    dma_byte(1'b0, 8'h00, 1'b1);
    chk("eop_done", 32'(done), 32'd1);
    chk("eop_xfer", 32'(xfer_count), 32'd3);
    dreq_quiet("dreq_after_eop");
    arm = 1'b0;
    cyc(1);
    arm = 1'b1;
    cyc(1);
    chk("rearm_done", 32'(done), 32'd0);
    chk("rearm_xfer", 32'(xfer_count), 32'd0);
    bus_q.push_back(8'h44);
    dma_byte(1'b0, 8'h00, 1'b0);
    chk("rearm_xfer_1", 32'(xfer_count), 32'd1);

    // DACK without any strobe: no transfer, re-request after returning to idle
    push_local(8'h77); bus_q.push_back(8'h77);
    wait_dreq("dreq_77");
    @(posedge CLK); #1;
    DACK = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    DACK = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    chk("dreq_no_early", 32'(DREQ), 32'd0);
    @(negedge CLK);
    chk("dreq_reassert", 32'(DREQ), 32'd1);
    chk("xfer_nostrobe", 32'(xfer_count), 32'd1);
    dma_byte(1'b0, 8'h00, 1'b0);
    chk("xfer_after_77", 32'(xfer_count), 32'd2);

    // Asynchronous reset while the bus is being driven
    push_local(8'h99); bus_q.push_back(8'h99);
    wait_dreq("dreq_99");
    @(posedge CLK); #1;
    DACK = 1'b1;
    @(posedge CLK); #1;
    IOR_N = 1'b0;
    @(negedge CLK);
    chk("oe_before_rst", 32'(DB_oe), 32'd1);
    #2;
    RESET = 1'b1;
    #1;
    chk("oe_async_rst", 32'(DB_oe), 32'd0);
    chk("dreq_async_rst", 32'(DREQ), 32'd0);
    @(negedge CLK);
    chk("rst2_xfer", 32'(xfer_count), 32'd0);
    chk("rst2_s_ready", 32'(s_ready), 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0; DACK = 1'b0; IOR_N = 1'b1;
    cyc(2);
    chk("rst2_s_ready_empty", 32'(s_ready), 32'd1);
    dreq_quiet("rst2_fifo_empty");

    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    chk("m_q_drained", 32'(m_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
